// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and helpers for the sequential binary-to-BCD converter
// Contents:
//   state_t      : converter sequencing states (IDLE, SHIFT, DONE)
//   BCD_W        : bits per BCD digit
//   add3_if_ge5  : double-dabble digit correction applied before each shift
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_W = 4;

  // A digit of 5..9 would become >= 10 after doubling; pre-adding 3 makes
  // the following left shift carry correctly into the next digit.
  function automatic logic [BCD_W-1:0] add3_if_ge5(input logic [BCD_W-1:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - combinational per-digit add-3 correction
// Ports:
//   din  : working BCD digit before correction
//   dout : din + 3 when din >= 5, otherwise din
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] din,
  output logic [BCD_W-1:0] dout
);

  assign dout = add3_if_ge5(din);

endmodule

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble binary-to-BCD converter, one bit per clock
// Ports:
//   clk         : clock, all state on rising edge
//   rst         : synchronous active-high reset, overrides start
//   start       : conversion request, honoured in IDLE and DONE only
//   signed_mode : 1 = bin_in is two's complement, 0 = unsigned
//   bin_in      : value to convert, sampled with an accepted start
//   busy        : high for the WIDTH shift cycles of a conversion
//   done        : one-cycle pulse, results valid in the same cycle
//   bcd_out     : DIGITS packed BCD digits, units in [3:0]
//   signal      : 1 = non-negative result, 0 = negative
//   overflow    : magnitude did not fit in DIGITS digits (bcd_out is modulo 10^DIGITS)
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    signed_mode,
  input  logic [WIDTH-1:0]        bin_in,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] bcd_out,
  output logic                    signal,
  output logic                    overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam int BW = BCD_W * DIGITS;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [BW-1:0]    work_q, work_d;
  logic             ovf_acc_q, ovf_acc_d;
  logic             neg_q, neg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bcd_out_q, bcd_out_d;
  logic             signal_q, signal_d;
  logic             overflow_q, overflow_d;

  logic [BW-1:0]    adj;
  logic [BW-1:0]    work_shift;
  logic             carry_out;
  logic             accept;
  logic             last_shift;
  logic             in_neg;

  // Add-3 correction on every working digit in parallel.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (work_q[g*BCD_W +: BCD_W]),
      .dout (adj[g*BCD_W +: BCD_W])
    );
  end

  // One left shift of {digits, magnitude}: magnitude MSB enters the units
  // digit, the top digit's MSB falls out and marks an overflow.
  assign work_shift = {adj[BW-2:0], mag_q[WIDTH-1]};
  assign carry_out  = adj[BW-1];

  // DONE accepts a new start exactly like IDLE, which gives back-to-back
  // conversions every WIDTH+1 cycles.
  assign accept     = start && (state_q != SHIFT);
  assign last_shift = (state_q == SHIFT) && (cnt_q == '0);
  assign in_neg     = signed_mode && bin_in[WIDTH-1];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE);
  end

  // Datapath next values
  always_comb begin
    mag_d      = mag_q;
    work_d     = work_q;
    ovf_acc_d  = ovf_acc_q;
    neg_d      = neg_q;
    cnt_d      = cnt_q;
    bcd_out_d  = bcd_out_q;
    signal_d   = signal_q;
    overflow_d = overflow_q;

    if (accept) begin
      // -2^(WIDTH-1) negates to 2^(WIDTH-1), which still fits unsigned.
      mag_d     = in_neg ? ((~bin_in) + WIDTH'(1)) : bin_in;
      neg_d     = in_neg;
      work_d    = '0;
      ovf_acc_d = 1'b0;
      cnt_d     = CW'(WIDTH - 1);
    end else if (state_q == SHIFT) begin
      mag_d     = {mag_q[WIDTH-2:0], 1'b0};
      work_d    = work_shift;
      ovf_acc_d = ovf_acc_q | carry_out;
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end
    end

    // Results are captured from the final shift so they are already on the
    // outputs during the done pulse, and then held until the next one.
    if (last_shift) begin
      bcd_out_d  = work_shift;
      signal_d   = ~neg_q;
      overflow_d = ovf_acc_q | carry_out;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mag_q      <= '0;
      work_q     <= '0;
      ovf_acc_q  <= 1'b0;
      neg_q      <= 1'b0;
      cnt_q      <= '0;
      bcd_out_q  <= '0;
      signal_q   <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      mag_q      <= mag_d;
      work_q     <= work_d;
      ovf_acc_q  <= ovf_acc_d;
      neg_q      <= neg_d;
      cnt_q      <= cnt_d;
      bcd_out_q  <= bcd_out_d;
      signal_q   <= signal_d;
      overflow_q <= overflow_d;
    end
  end

  assign bcd_out  = bcd_out_q;
  assign signal   = signal_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - self-checking bench for bin_to_bcd_seq (32b/10 digits and 16b/3 digits)
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst, start, signed_mode;
  logic [31:0] bin_in;
  logic        busy, done, signal, overflow;
  logic [39:0] bcd_out;

  logic        start3, signed_mode3;
  logic [15:0] bin3;
  logic        busy3, done3, signal3, overflow3;
  logic [11:0] bcd3;

  bin_to_bcd_seq #(.WIDTH(32), .DIGITS(10)) u_dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .signal(signal), .overflow(overflow)
  );

  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .signed_mode(signed_mode3), .bin_in(bin3),
    .busy(busy3), .done(done3), .bcd_out(bcd3), .signal(signal3), .overflow(overflow3)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [39:0] bcd;
    logic        sign;
    logic        ovf;
    int          done_cyc;
  } exp_t;

  typedef struct {
    logic        sm;
    logic [31:0] bin;
    logic [39:0] bcd;
    logic        sign;
    logic        ovf;
  } vec_t;

  exp_t sb_q[$];
  exp_t sb3_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   busy_cnt = 0;
  int   busy3_cnt = 0;

  // Scoreboard for the 32-bit instance
  always @(negedge clk) begin : mon10
    exp_t e;
    if (rst) busy_cnt = 0;
    else if (busy) busy_cnt++;
    if (done) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_done10 at cyc %0d: bcd=%h, required no done", cyc, bcd_out);
      end else begin
        e = sb_q.pop_front();
        if (bcd_out !== e.bcd || signal !== e.sign || overflow !== e.ovf ||
            cyc != e.done_cyc || busy_cnt != 32) begin
          n_bad++;
          $display("FAIL result10: got bcd=%h sign=%b ovf=%b done_cyc=%0d busy=%0d, required bcd=%h sign=%b ovf=%b done_cyc=%0d busy=32",
                   bcd_out, signal, overflow, cyc, busy_cnt, e.bcd, e.sign, e.ovf, e.done_cyc);
        end
      end
      busy_cnt = 0;
    end
  end

  // Scoreboard for the 16-bit / 3-digit instance
  always @(negedge clk) begin : mon3
    exp_t e;
    if (rst) busy3_cnt = 0;
    else if (busy3) busy3_cnt++;
    if (done3) begin
      n_vec++;
      if (sb3_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_done3 at cyc %0d: bcd=%h, required no done", cyc, bcd3);
      end else begin
        e = sb3_q.pop_front();
        if (bcd3 !== e.bcd[11:0] || signal3 !== e.sign || overflow3 !== e.ovf ||
            cyc != e.done_cyc || busy3_cnt != 16) begin
          n_bad++;
          $display("FAIL result3: got bcd=%h sign=%b ovf=%b done_cyc=%0d busy=%0d, required bcd=%h sign=%b ovf=%b done_cyc=%0d busy=16",
                   bcd3, signal3, overflow3, cyc, busy3_cnt, e.bcd[11:0], e.sign, e.ovf, e.done_cyc);
        end
      end
      busy3_cnt = 0;
    end
  end

  function automatic logic [39:0] to_bcd(input longint unsigned m, input int nd);
    logic [39:0] r;
    r = '0;
    for (int i = 0; i < nd; i++) begin
      r[i*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Called just after a rising edge with the DUT idle (or in DONE).
  task automatic start_conv(input logic sm, input logic [31:0] v,
                            input logic [39:0] eb, input logic es, input logic eo);
    signed_mode = sm;
    bin_in      = v;
    start       = 1'b1;
    sb_q.push_back('{eb, es, eo, cyc + 1 + 32});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic start_conv3(input logic sm, input logic [15:0] v,
                             input logic [11:0] eb, input logic es, input logic eo);
    signed_mode3 = sm;
    bin3         = v;
    start3       = 1'b1;
    sb3_q.push_back('{{28'd0, eb}, es, eo, cyc + 1 + 16});
    @(posedge clk); #1;
    start3 = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    for (k = 0; k < 80; k++) begin
      if (sb_q.size() == 0 && sb3_q.size() == 0) break;
      @(posedge clk); #1;
    end
    if (k == 80) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: %0d+%0d results pending, required 0", sb_q.size(), sb3_q.size());
      sb_q.delete();
      sb3_q.delete();
    end
  endtask

  vec_t vt[9];
  vec_t v3[5];

  initial begin
    logic [31:0] rv;
    logic        rs;
    logic [31:0] rmag;

    vt[0] = '{1'b0, 32'd0,          40'h0000000000, 1'b1, 1'b0};
    vt[1] = '{1'b0, 32'hFFFF_FFFF,  40'h4294967295, 1'b1, 1'b0};
    vt[2] = '{1'b1, 32'hFFFF_FFFF,  40'h0000000001, 1'b0, 1'b0};
    vt[3] = '{1'b1, 32'h8000_0000,  40'h2147483648, 1'b0, 1'b0};
    vt[4] = '{1'b1, 32'd0,          40'h0000000000, 1'b1, 1'b0};
    vt[5] = '{1'b1, 32'h7FFF_FFFF,  40'h2147483647, 1'b1, 1'b0};
    vt[6] = '{1'b0, 32'h8000_0000,  40'h2147483648, 1'b1, 1'b0};
    vt[7] = '{1'b1, 32'hFFFF_FC18,  40'h0000001000, 1'b0, 1'b0};
    vt[8] = '{1'b0, 32'd12345678,   40'h0012345678, 1'b1, 1'b0};

    v3[0] = '{1'b0, 32'd1234,   40'h234, 1'b1, 1'b1};
    v3[1] = '{1'b0, 32'd999,    40'h999, 1'b1, 1'b0};
    v3[2] = '{1'b0, 32'd1000,   40'h000, 1'b1, 1'b1};
    v3[3] = '{1'b1, 32'hFC19,   40'h999, 1'b0, 1'b0};
    v3[4] = '{1'b1, 32'hFC18,   40'h000, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; bin_in = '0;
    start3 = 1'b0; signed_mode3 = 1'b0; bin3 = '0;
    repeat (3) @(posedge clk);
    #1;
    // rst must win over a simultaneous start
    start = 1'b1; bin_in = 32'd42; start3 = 1'b1; bin3 = 16'd42;
    @(posedge clk); #1;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_bcd", {24'd0, bcd_out}, 64'd0);
    chk("reset_signal", {63'd0, signal}, 64'd1);
    chk("reset_overflow", {63'd0, overflow}, 64'd0);
    chk("reset_busy3", {63'd0, busy3}, 64'd0);
    start = 1'b0; start3 = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_no_start_busy", {63'd0, busy}, 64'd0);

    for (int i = 0; i < 9; i++) begin
      start_conv(vt[i].sm, vt[i].bin, vt[i].bcd, vt[i].sign, vt[i].ovf);
      wait_drain();
    end

    repeat (5) @(posedge clk);
    #1;
    chk("hold_bcd", {24'd0, bcd_out}, {24'd0, vt[8].bcd});
    chk("hold_signal", {63'd0, signal}, {63'd0, vt[8].sign});

    for (int i = 0; i < 8; i++) begin
      rv   = $urandom();
      rs   = 1'($urandom_range(0, 1));
      rmag = (rs && rv[31]) ? (32'd0 - rv) : rv;
      start_conv(rs, rv, to_bcd(64'(rmag), 10), !(rs && rv[31]), 1'b0);
      wait_drain();
    end

    // start while busy is ignored; bin_in changes during SHIFT have no effect
    start_conv(1'b0, 32'd55555, 40'h0000055555, 1'b1, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1; bin_in = 32'd777;
    @(posedge clk); #1;
    start = 1'b0; bin_in = 32'd31337;
    wait_drain();

    // start in the DONE cycle: second done exactly 33 cycles after the first
    start_conv(1'b1, 32'hFFFF_CFC7, 40'h0000012345, 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) break;
    end
    start_conv(1'b0, 32'd98765, 40'h0000098765, 1'b1, 1'b0);
    wait_drain();

    // reset in the middle of a conversion: abort, no done
    signed_mode = 1'b1; bin_in = 32'hDEAD_BEEF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("abort_busy_before", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_bcd", {24'd0, bcd_out}, 64'd0);
    chk("abort_signal", {63'd0, signal}, 64'd1);
    chk("abort_overflow", {63'd0, overflow}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    start_conv(1'b0, 32'd4000000000, 40'h4000000000, 1'b1, 1'b0);
    wait_drain();

    // narrow instance: overflow wraps modulo 1000
    for (int i = 0; i < 5; i++) begin
      start_conv3(v3[i].sm, v3[i].bin[15:0], v3[i].bcd[11:0], v3[i].sign, v3[i].ovf);
      wait_drain();
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
